// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host definitions: FSM state encoding, command bytes, timing constants
// and the odd-parity helper used by the transmitter and the keyboard receiver.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    localparam int         SYNC_IDLE_COUNT  = 16;
    localparam int         DATA_LEAD_CYCLES = 10;
    localparam logic [1:0] MAX_RETRIES      = 2'd2;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the async PS/2 clock and data lines and flags falling edges of the
// synchronised clock; shared by the host transmitter and the keyboard receiver.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic [SYNC_STAGES-1:0] r_clk_sh;
    logic [SYNC_STAGES-1:0] r_data_sh;
    logic                   r_clk_prev;

    // Reset to the released (pulled-up) level so no spurious edge follows reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sh   <= {SYNC_STAGES{1'b1}};
            r_data_sh  <= {SYNC_STAGES{1'b1}};
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sh   <= {r_clk_sh[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sh  <= {r_data_sh[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev <= r_clk_sh[SYNC_STAGES-1];
        end
    end

    assign o_clk_sync  = r_clk_sh[SYNC_STAGES-1];
    assign o_data_sync = r_data_sh[SYNC_STAGES-1];
    assign o_clk_fall  = r_clk_prev & ~r_clk_sh[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clk/data via *_oe).
// Optional macro PS2_TX_RETRY_EN: retry NACK/timeout up to twice before tx_err.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam int CNT_W    = (INH_W > 5) ? INH_W : 5;
    localparam int DOE_FROM = (INHIBIT_CYCLES > DATA_LEAD_CYCLES) ?
                              (INHIBIT_CYCLES - DATA_LEAD_CYCLES - 1) : 0;

    localparam logic [CNT_W-1:0] INH_LAST      = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOE_FROM_C    = CNT_W'(DOE_FROM);
    localparam logic [CNT_W-1:0] IDLE_LAST     = CNT_W'(SYNC_IDLE_COUNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             DOE_AT_ACCEPT = (INHIBIT_CYCLES <= DATA_LEAD_CYCLES) ? 1'b1 : 1'b0;

    ps2_state_e       r_state;
    logic [7:0]       r_byte;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_nack;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_tx_ready;
    logic             r_rx_inhibit;
    logic             r_done;
    logic             r_err;

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fall;
    logic w_framing;
    logic w_timeout;
    logic w_idle_done;
    logic w_fail;
    logic w_can_retry;

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_clk_fall  (w_clk_fall)
    );

    assign w_framing   = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_timeout   = w_framing && (r_to_cnt == TO_LAST);
    assign w_idle_done = (r_state == ST_WAIT_IDLE) && w_clk_sync && w_data_sync &&
                         (r_cnt == IDLE_LAST);
    assign w_fail      = w_timeout || (w_idle_done && r_nack);

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_retry;

    // Retries consumed on the byte currently in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry <= 2'd0;
        end else if (r_state == ST_IDLE) begin
            r_retry <= 2'd0;
        end else if (w_fail && w_can_retry) begin
            r_retry <= r_retry + 2'd1;
        end else begin
            r_retry <= r_retry;
        end
    end

    assign w_can_retry = (r_retry < MAX_RETRIES);
`else
    assign w_can_retry = 1'b0;
`endif

    // Transmit FSM; failure (NACK or timeout) takes priority over normal sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte       <= 8'h00;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_nack       <= 1'b0;
            r_clk_oe     <= 1'b0;
            r_data_oe    <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_rx_inhibit <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_framing) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= r_to_cnt;
            end
            if (w_fail) begin
                if (w_can_retry) begin
                    r_state   <= ST_INHIBIT;
                    r_shift   <= r_byte;
                    r_cnt     <= '0;
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= DOE_AT_ACCEPT;
                end else begin
                    r_state      <= ST_IDLE;
                    r_clk_oe     <= 1'b0;
                    r_data_oe    <= 1'b0;
                    r_tx_ready   <= 1'b1;
                    r_rx_inhibit <= 1'b0;
                    r_err        <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tx_valid && r_tx_ready) begin
                            r_state      <= ST_INHIBIT;
                            r_byte       <= tx_data;
                            r_shift      <= tx_data;
                            r_parity     <= odd_parity(tx_data);
                            r_cnt        <= '0;
                            r_clk_oe     <= 1'b1;
                            r_data_oe    <= DOE_AT_ACCEPT;
                            r_tx_ready   <= 1'b0;
                            r_rx_inhibit <= 1'b1;
                        end else begin
                            r_clk_oe  <= 1'b0;
                            r_data_oe <= 1'b0;
                        end
                    end
                    ST_INHIBIT: begin
                        if (r_cnt == INH_LAST) begin
                            r_state   <= ST_START;
                            r_clk_oe  <= 1'b0;
                            r_data_oe <= 1'b1;
                            r_to_cnt  <= '0;
                        end else begin
                            r_cnt     <= r_cnt + CNT_W'(1);
                            r_data_oe <= (r_cnt >= DOE_FROM_C);
                        end
                    end
                    ST_START: begin
                        if (w_clk_fall) begin
                            r_state   <= ST_DATA;
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_state <= ST_START;
                        end
                    end
                    ST_DATA: begin
                        if (w_clk_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_state   <= ST_PARITY;
                                r_data_oe <= ~r_parity;
                            end else begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        if (w_clk_fall) begin
                            r_state   <= ST_STOP;
                            r_data_oe <= 1'b0;
                        end else begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_STOP: begin
                        if (w_clk_fall) begin
                            r_state <= ST_WAIT_IDLE;
                            r_nack  <= w_data_sync;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_STOP;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_clk_sync && w_data_sync) begin
                            if (r_cnt == IDLE_LAST) begin
                                r_state      <= ST_IDLE;
                                r_tx_ready   <= 1'b1;
                                r_rx_inhibit <= 1'b0;
                                r_done       <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_clk_oe     <= 1'b0;
                        r_data_oe    <= 1'b0;
                        r_tx_ready   <= 1'b1;
                        r_rx_inhibit <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign rx_inhibit  = r_rx_inhibit;
    assign tx_done     = r_done;
    assign tx_err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: behavioural keyboard driving the PS/2 clock and
// sampling on its rising edge; honours PS2_TX_RETRY_EN for retry expectations.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 40;
    localparam int TO   = 2000;
    localparam int SYNC = 2;
    localparam int H    = 20;
    localparam int LIM  = 1000;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, attempts = 0;
    int hold_len = 0, lead_len = 0, last_hold = 0, last_lead = 0;
    int start_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // Pulse counters, inhibit hold measurement and START-entry timestamps
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe && !prev_clk_oe) attempts <= attempts + 1;
        if (ps2_clk_oe) begin
            hold_len <= hold_len + 1;
            if (ps2_data_oe) lead_len <= lead_len + 1;
        end else begin
            if (prev_clk_oe) begin
                last_hold <= hold_len;
                last_lead <= lead_len;
                if (rx_inhibit) start_cyc <= cyc;
            end
            hold_len <= 0;
            lead_len <= 0;
        end
        prev_clk_oe <= ps2_clk_oe;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_outcome(input int base, input int limit, output bit hit);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == base && n < limit) begin
            @(negedge clk);
            n++;
        end
        hit = ((done_cnt + err_cnt) != base);
        repeat (5) @(negedge clk);
    endtask

    task automatic dev_frame(input bit ack, output bit ok, output logic start_bit,
                             output logic [7:0] b, output logic par, output logic stp);
        int n;
        ok = 1'b1; start_bit = 1'b1; b = 8'h00; par = 1'b0; stp = 1'b0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) ok = 1'b0;
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) ok = 1'b0;
        if (ok) begin
            repeat (H) @(negedge clk);
            start_bit = ps2_data_in;
            for (int k = 1; k <= 11; k++) begin
                if (k == 11 && ack) dev_data_low = 1'b1;
                dev_clk_low = 1'b1;
                repeat (H) @(negedge clk);
                dev_clk_low = 1'b0;
                @(negedge clk);
                if (k <= 8) b[k-1] = ps2_data_in;
                else if (k == 9) par = ps2_data_in;
                else if (k == 10) stp = ps2_data_in;
                repeat (H - 1) @(negedge clk);
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
        checks++; if (rx_inhibit !== 1'b0) begin errors++; $display("FAIL reset_inhibit got=%b exp=0", rx_inhibit); end
        checks++; if ({tx_done, tx_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", tx_done, tx_err); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_set_led();
        bit ok, hit;
        logic st, par, stp;
        logic [7:0] b;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(PS2_CMD_SET_LED);
        checks++; if ({tx_ready, rx_inhibit} !== 2'b01) begin errors++; $display("FAIL led_busy ready/inhibit got=%b%b exp=01", tx_ready, rx_inhibit); end
        dev_frame(1'b1, ok, st, b, par, stp);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL led_frame_start got=%b exp=1", ok); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL led_start_bit got=%b exp=0", st); end
        checks++; if (b !== 8'hED) begin errors++; $display("FAIL led_bits got=%h exp=ed", b); end
        checks++; if (par !== 1'b1) begin errors++; $display("FAIL led_parity got=%b exp=1", par); end
        checks++; if (stp !== 1'b1) begin errors++; $display("FAIL led_stop got=%b exp=1", stp); end
        wait_outcome(d0 + e0, 200, hit);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL led_outcome_timeout got=%b exp=1", hit); end
        checks++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL led_done done=%0d err=%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
        checks++; if ({tx_ready, rx_inhibit} !== 2'b10) begin errors++; $display("FAIL led_idle ready/inhibit got=%b%b exp=10", tx_ready, rx_inhibit); end
    endtask

    task automatic test_inhibit_timing();
        checks++; if (last_hold < INH) begin errors++; $display("FAIL inhibit_hold got=%0d exp>=%0d", last_hold, INH); end
        checks++; if (last_lead !== 10) begin errors++; $display("FAIL inhibit_data_lead got=%0d exp=10", last_lead); end
    endtask

    task automatic test_parity();
        logic [7:0] vec [2];
        logic       exp_par [2];
        bit ok, hit;
        logic st, par, stp;
        logic [7:0] b;
        int d0;
        vec[0] = 8'h00; exp_par[0] = 1'b1;
        vec[1] = 8'h01; exp_par[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d0 = done_cnt + err_cnt;
            send_byte(vec[i]);
            dev_frame(1'b1, ok, st, b, par, stp);
            checks++; if (b !== vec[i]) begin errors++; $display("FAIL parity_bits[%0d] got=%h exp=%h", i, b, vec[i]); end
            checks++; if (par !== exp_par[i]) begin errors++; $display("FAIL parity_bit[%0d] got=%b exp=%b", i, par, exp_par[i]); end
            wait_outcome(d0, 200, hit);
            checks++; if (hit !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL parity_done[%0d] hit=%b ready=%b exp=1/1", i, hit, tx_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [2];
        logic       exp_par [2];
        bit ok, hit;
        logic st, par, stp;
        logic [7:0] b;
        int d0;
        vec[0] = PS2_CMD_RESET; exp_par[0] = 1'b1;
        vec[1] = PS2_ACK_BYTE;  exp_par[1] = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            send_byte(vec[i]);
            dev_frame(1'b1, ok, st, b, par, stp);
            checks++; if ({b, par, stp} !== {vec[i], exp_par[i], 1'b1}) begin errors++; $display("FAIL b2b_frame[%0d] got=%h/%b/%b exp=%h/%b/1", i, b, par, stp, vec[i], exp_par[i]); end
            wait_outcome(done_cnt + err_cnt, 200, hit);
        end
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
    endtask

    task automatic test_busy_ignored();
        bit ok, hit;
        logic st, par, stp;
        logic [7:0] b;
        int n, d0, a0;
        d0 = done_cnt + err_cnt; a0 = attempts;
        @(negedge clk);
        tx_data = PS2_CMD_SET_LED; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b1, ok, st, b, par, stp);
        checks++; if (b !== 8'hED) begin errors++; $display("FAIL busy_byte got=%h exp=ed", b); end
        wait_outcome(d0, 200, hit);
        repeat (INH + 10) @(negedge clk);
        checks++; if (attempts - a0 !== 1) begin errors++; $display("FAIL busy_frames got=%0d exp=1", attempts - a0); end
    endtask

    task automatic test_nack();
        bit ok, hit;
        logic st, par, stp;
        logic [7:0] b;
        int d0, e0, a0;
        d0 = done_cnt; e0 = err_cnt; a0 = attempts;
        send_byte(8'h3C);
        for (int i = 0; i < ATTEMPTS; i++) begin
            dev_frame(1'b0, ok, st, b, par, stp);
            checks++; if (ok !== 1'b1 || b !== 8'h3C) begin errors++; $display("FAIL nack_frame[%0d] ok=%b byte=%h exp=1/3c", i, ok, b); end
        end
        wait_outcome(d0 + e0, 200, hit);
        checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL nack_err err=%0d done=%0d exp=1/0", err_cnt - e0, done_cnt - d0); end
        checks++; if (attempts - a0 !== ATTEMPTS) begin errors++; $display("FAIL nack_attempts got=%0d exp=%0d", attempts - a0, ATTEMPTS); end
    endtask

    task automatic test_timeout();
        bit hit;
        int d0, e0, a0;
        d0 = done_cnt; e0 = err_cnt; a0 = attempts;
        send_byte(8'hF4);
        wait_outcome(d0 + e0, ATTEMPTS * (INH + TO) + 500, hit);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL timeout_no_outcome got=%b exp=1", hit); end
        checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_err err=%0d done=%0d exp=1/0", err_cnt - e0, done_cnt - d0); end
        checks++; if (err_cyc - start_cyc !== TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", err_cyc - start_cyc, TO); end
        checks++; if (attempts - a0 !== ATTEMPTS) begin errors++; $display("FAIL timeout_attempts got=%0d exp=%0d", attempts - a0, ATTEMPTS); end
        checks++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin errors++; $display("FAIL timeout_release got=%b%b%b exp=001", ps2_clk_oe, ps2_data_oe, tx_ready); end
    endtask

    task automatic test_reset_mid_data();
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h5A);
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
        repeat (H) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        checks++; if (rx_inhibit !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", rx_inhibit); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL mid_rst_oe got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
        checks++; if ({tx_ready, rx_inhibit} !== 2'b10) begin errors++; $display("FAIL mid_rst_ready got=%b%b exp=10", tx_ready, rx_inhibit); end
        repeat (40) @(negedge clk);
        checks++; if (done_cnt !== d0 || err_cnt !== e0) begin errors++; $display("FAIL mid_rst_pulses done=%0d err=%0d exp=%0d/%0d", done_cnt, err_cnt, d0, e0); end
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_inhibit_timing();
        test_parity();
        test_back_to_back();
        test_busy_ignored();
        test_nack();
        test_timeout();
        test_reset_mid_data();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_same_cycle got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
